retta_mem_writer: RTL and testbench

Sequential generator that fills the 16-byte point table read by the downstream line-point counter. It writes 8 (x, y) pairs at addresses (0,1), (2,3) … (14,15). Exactly TARGET of those pairs satisfy the counter's on-line test and the rest fail it. This gives benches and self-test a table whose expected PUNTI_RETTA result is known ahead of time.

---
 rtl/retta_mem_writer_pkg.sv | 45 ++++
 rtl/retta_mem_writer_if.sv | 31 +++
 rtl/retta_mem_writer_lfsr8.sv | 39 +++
 rtl/retta_mem_writer.sv | 154 +++++++++++++++
 tb/tb_retta_mem_writer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/retta_mem_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : retta_pkg
//  Description : Shared types, constants and the on-line test used by the
//                point-table writer and by anything that checks its table.
//  Revision    : 1.0 - initial release
// ============================================================================
package retta_pkg;

  localparam int          TABLE_DEPTH = 16;
  localparam int          NPAIRS      = 8;
  localparam int          ADDR_W      = $clog2(TABLE_DEPTH);
  localparam logic [7:0]  LFSR_TAPS   = 8'hB8;

  // x values whose (3*x mod 128) lands in {0,1,2}; indexed by LFSR[2:0]
  localparam logic [7:0] ONLINE_X [0:7] = '{
    8'd0, 8'd43, 8'd86, 8'd128, 8'd171, 8'd214, 8'd0, 8'd43
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR_X = 2'd1,
    S_WR_Y = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // 3*x mod 128, built as x + 2x in 7 bits so the wrap is implicit
  function automatic logic [6:0] line_m(input logic [6:0] x);
    return x + {x[5:0], 1'b0};
  endfunction

  // The counter's test: m + y as an 8-bit sum must be exactly 2
  function automatic logic on_line(input logic [6:0] x, input logic [6:0] y);
    logic [7:0] s;
    s = {1'b0, line_m(x)} + {1'b0, y};
    return (s == 8'd2);
  endfunction

  // Galois right-shift step with the package taps
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return v[0] ? ({1'b0, v[7:1]} ^ LFSR_TAPS) : {1'b0, v[7:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/retta_mem_writer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : retta_mem_writer_if
//  Description : Control inputs and table-write/status outputs of the
//                point-table writer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface retta_mem_writer_if;
  logic       GO;
  logic [3:0] TARGET;
  logic [7:0] SEED;
  logic       WE;
  logic [3:0] WADDR;
  logic [7:0] WDATA;
  logic       BUSY;
  logic       DONE;
  logic [7:0] EXPECTED;

  // Writer side
  modport master (
    input  GO, TARGET, SEED,
    output WE, WADDR, WDATA, BUSY, DONE, EXPECTED
  );

  // Controller / table side
  modport slave (
    output GO, TARGET, SEED,
    input  WE, WADDR, WDATA, BUSY, DONE, EXPECTED
  );
endinterface
`default_nettype wire

// File: rtl/retta_mem_writer_lfsr8.sv
`default_nettype none
// ============================================================================
//  Module      : retta_lfsr8
//  Description : 8-bit Galois LFSR with load (zero seed forced to 01) and
//                step. next_value exposes the value after this edge so the
//                caller can register outputs that depend on it.
//  Revision    : 1.0 - initial release
// ============================================================================
module retta_lfsr8
  import retta_pkg::*;
(
  input  wire logic       clock,
  input  wire logic       reset,
  input  wire logic       load,
  input  wire logic [7:0] load_value,
  input  wire logic       step,
  output logic [7:0]      value,
  output logic [7:0]      next_value
);

  // Load has priority; an all-zero seed would lock the LFSR, so use 01
  always_comb begin
    next_value = value;
    if (load)
      next_value = (load_value == 8'h00) ? 8'h01 : load_value;
    else if (step)
      next_value = lfsr_next(value);
  end

  // LFSR state register
  always_ff @(posedge clock) begin
    if (reset)
      value <= 8'h01;
    else
      value <= next_value;
  end

endmodule
`default_nettype wire

// File: rtl/retta_mem_writer.sv
`default_nettype none
// ============================================================================
//  Module      : retta_mem_writer
//  Description : Fills a 16-byte point table with 8 (x,y) pairs of which
//                exactly min(TARGET,8) pass the line-point counter's test.
//                All outputs are registered: the comb block computes the
//                values for the cycle after the coming edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module retta_mem_writer
  import retta_pkg::*;
(
  input  wire logic            clock,
  input  wire logic            reset,
  retta_mem_writer_if.master   bus
);

  state_t      state, state_nxt;
  logic [2:0]  p, p_nxt;
  logic [3:0]  t_lat, t_nxt;
  logic [6:0]  x_lat, x_nxt;
  logic        lfsr_load, lfsr_step;
  logic [7:0]  lfsr_val, lfsr_nxt;
  logic [3:0]  target_clamped;
  logic [7:0]  y_on, y_off;

  logic        we_q, busy_q, done_q;
  logic [3:0]  waddr_q;
  logic [7:0]  wdata_q, expected_q;
  logic        we_nxt, busy_nxt, done_nxt;
  logic [3:0]  waddr_nxt;
  logic [7:0]  wdata_nxt, expected_nxt;

  retta_lfsr8 u_lfsr (
    .clock      (clock),
    .reset      (reset),
    .load       (lfsr_load),
    .load_value (bus.SEED),
    .step       (lfsr_step),
    .value      (lfsr_val),
    .next_value (lfsr_nxt)
  );

  assign target_clamped = (bus.TARGET > 4'd8) ? 4'd8 : bus.TARGET;

  // y candidates for the WR_Y cycle, using the LFSR value that cycle will see
  always_comb begin
    y_on  = {lfsr_nxt[7], 7'd2 - line_m(x_lat)};
    y_off = on_line(x_lat, lfsr_nxt[6:0]) ? (lfsr_nxt ^ 8'h01) : lfsr_nxt;
  end

  // Next-state, counters and next-cycle output values
  always_comb begin
    state_nxt    = state;
    p_nxt        = p;
    t_nxt        = t_lat;
    x_nxt        = x_lat;
    lfsr_load    = 1'b0;
    lfsr_step    = 1'b0;
    we_nxt       = 1'b0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    waddr_nxt    = '0;
    wdata_nxt    = '0;
    expected_nxt = expected_q;

    case (state)
      S_IDLE: begin
        if (bus.GO) begin
          state_nxt = S_WR_X;
          lfsr_load = 1'b1;
          p_nxt     = 3'd0;
          t_nxt     = target_clamped;
          we_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          waddr_nxt = 4'd0;
          wdata_nxt = (target_clamped != 4'd0) ? ONLINE_X[lfsr_nxt[2:0]] : lfsr_nxt;
          x_nxt     = wdata_nxt[6:0];
        end
      end

      S_WR_X: begin
        state_nxt = S_WR_Y;
        lfsr_step = 1'b1;
        we_nxt    = 1'b1;
        busy_nxt  = 1'b1;
        waddr_nxt = {p, 1'b1};
        wdata_nxt = ({1'b0, p} < t_lat) ? y_on : y_off;
      end

      S_WR_Y: begin
        lfsr_step = 1'b1;
        p_nxt     = p + 3'd1;
        if (p == 3'(NPAIRS - 1)) begin
          state_nxt    = S_FIN;
          done_nxt     = 1'b1;
          busy_nxt     = 1'b1;
          expected_nxt = {4'd0, t_lat};
        end else begin
          state_nxt = S_WR_X;
          we_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          waddr_nxt = {p_nxt, 1'b0};
          wdata_nxt = ({1'b0, p_nxt} < t_lat) ? ONLINE_X[lfsr_nxt[2:0]] : lfsr_nxt;
          x_nxt     = wdata_nxt[6:0];
        end
      end

      S_FIN: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      p          <= 3'd0;
      t_lat      <= 4'd0;
      x_lat      <= 7'd0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      waddr_q    <= 4'd0;
      wdata_q    <= 8'd0;
      expected_q <= 8'd0;
    end else begin
      state      <= state_nxt;
      p          <= p_nxt;
      t_lat      <= t_nxt;
      x_lat      <= x_nxt;
      we_q       <= we_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
      waddr_q    <= waddr_nxt;
      wdata_q    <= wdata_nxt;
      expected_q <= expected_nxt;
    end
  end

  assign bus.WE       = we_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.WADDR    = waddr_q;
  assign bus.WDATA    = wdata_q;
  assign bus.EXPECTED = expected_q;

endmodule
`default_nettype wire

// File: tb/tb_retta_mem_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_retta_mem_writer
//  Description : Directed bench for the point-table writer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_retta_mem_writer;
  import retta_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem  [0:15];
  logic [7:0] ref1 [0:15];
  logic [7:0] xtab [0:7];

  retta_mem_writer_if wr_if ();

  retta_mem_writer dut (
    .clock (clock),
    .reset (reset),
    .bus   (wr_if)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] step8(input logic [7:0] v);
    logic [7:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ 8'hB8;
    return s;
  endfunction

  // One run: model the write stream, check every cycle, optionally inject
  // a GO mid-run (go_at) or a reset mid-run (rst_at), both as loop indices.
  task automatic run(input logic [3:0] t, input logic [7:0] s, input int go_at,
                     input logic [3:0] t2, input int rst_at, input string nm);
    logic [7:0] ml, expd, xw;
    logic [6:0] mm;
    int tc, cnt;
    tc = (t > 4'd8) ? 8 : int'(t);
    ml = (s == 8'h00) ? 8'h01 : s;
    xw = 8'h00;
    wr_if.TARGET = t;
    wr_if.SEED   = s;
    wr_if.GO     = 1'b1;
    @(posedge clock); #1;
    wr_if.GO = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        expd = (i / 2 < tc) ? xtab[ml[2:0]] : ml;
        xw   = expd;
      end else begin
        mm = xw[6:0] * 7'd3;
        if (i / 2 < tc) expd = {ml[7], 7'd2 - mm};
        else            expd = (({1'b0, mm} + {1'b0, ml[6:0]}) == 8'd2) ? (ml ^ 8'h01) : ml;
      end
      ml = step8(ml);
      chk($sformatf("%s we[%0d]", nm, i), {7'd0, wr_if.WE}, 8'd1);
      chk($sformatf("%s busy[%0d]", nm, i), {7'd0, wr_if.BUSY}, 8'd1);
      chk($sformatf("%s done[%0d]", nm, i), {7'd0, wr_if.DONE}, 8'd0);
      chk($sformatf("%s addr[%0d]", nm, i), {4'd0, wr_if.WADDR}, 8'(i));
      chk($sformatf("%s data[%0d]", nm, i), wr_if.WDATA, expd);
      mem[i] = wr_if.WDATA;
      if (i == go_at) begin
        wr_if.GO = 1'b1;
        wr_if.TARGET = t2;
      end else begin
        wr_if.GO = 1'b0;
      end
      if (i == rst_at) reset = 1'b1;
      @(posedge clock); #1;
      if (i == rst_at) begin
        reset = 1'b0;
        chk({nm, " rst we"}, {7'd0, wr_if.WE}, 8'd0);
        chk({nm, " rst busy"}, {7'd0, wr_if.BUSY}, 8'd0);
        chk({nm, " rst done"}, {7'd0, wr_if.DONE}, 8'd0);
        chk({nm, " rst expected"}, wr_if.EXPECTED, 8'd0);
        return;
      end
    end
    wr_if.GO = 1'b0;
    chk({nm, " fin done"}, {7'd0, wr_if.DONE}, 8'd1);
    chk({nm, " fin busy"}, {7'd0, wr_if.BUSY}, 8'd1);
    chk({nm, " fin we"}, {7'd0, wr_if.WE}, 8'd0);
    chk({nm, " fin expected"}, wr_if.EXPECTED, 8'(tc));
    @(posedge clock); #1;
    chk({nm, " idle done"}, {7'd0, wr_if.DONE}, 8'd0);
    chk({nm, " idle busy"}, {7'd0, wr_if.BUSY}, 8'd0);
    chk({nm, " idle expected"}, wr_if.EXPECTED, 8'(tc));
    cnt = 0;
    for (int k = 0; k < 8; k++)
      if (on_line(mem[2*k][6:0], mem[2*k+1][6:0])) cnt++;
    chk({nm, " online count"}, 8'(cnt), 8'(tc));
  endtask

  initial begin
    int c1, c2, dseen;
    xtab[0] = 8'd0;   xtab[1] = 8'd43;  xtab[2] = 8'd86; xtab[3] = 8'd128;
    xtab[4] = 8'd171; xtab[5] = 8'd214; xtab[6] = 8'd0;  xtab[7] = 8'd43;
    wr_if.GO = 1'b0;
    wr_if.TARGET = 4'd0;
    wr_if.SEED = 8'h00;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("reset we", {7'd0, wr_if.WE}, 8'd0);
    chk("reset busy", {7'd0, wr_if.BUSY}, 8'd0);
    chk("reset done", {7'd0, wr_if.DONE}, 8'd0);
    chk("reset waddr", {4'd0, wr_if.WADDR}, 8'd0);
    chk("reset wdata", wr_if.WDATA, 8'd0);
    chk("reset expected", wr_if.EXPECTED, 8'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // All pairs on-line, seed 01; first two pairs hand-computed
    run(4'd8, 8'h01, -1, 4'd0, -1, "t8");
    chk("t8 mem0", mem[0], 8'h2B);
    chk("t8 mem1", mem[1], 8'h81);
    chk("t8 mem2", mem[2], 8'hAB);
    chk("t8 mem3", mem[3], 8'h01);
    for (int i = 0; i < 16; i++) ref1[i] = mem[i];

    // All pairs off-line, exercises the y fix-up where needed
    run(4'd0, 8'hA5, -1, 4'd0, -1, "t0");

    // Clamp and zero-seed substitution: same stream as the first run
    run(4'd12, 8'h00, -1, 4'd0, -1, "t12");
    for (int i = 0; i < 16; i++)
      chk($sformatf("t12 same[%0d]", i), mem[i], ref1[i]);

    // GO during the run is ignored
    run(4'd3, 8'h5A, 4, 4'd7, -1, "t3go");

    // Reset mid-run, then no DONE, then a clean run
    run(4'd5, 8'h77, -1, 4'd0, 5, "t5rst");
    dseen = 0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clock); #1;
      if (wr_if.DONE || wr_if.WE) dseen = 1;
    end
    chk("rst no done", 8'(dseen), 8'd0);
    chk("rst expected hold", wr_if.EXPECTED, 8'd0);
    run(4'd5, 8'h77, -1, 4'd0, -1, "t5");

    // Every TARGET value 0..8
    for (int k = 0; k <= 8; k++)
      run(4'(k), 8'h3C + 8'(k), -1, 4'd0, -1, $sformatf("k%0d", k));

    // GO held high: runs repeat every 18 cycles
    c1 = -1; c2 = -1;
    wr_if.TARGET = 4'd2;
    wr_if.SEED = 8'h11;
    wr_if.GO = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clock); #1;
      if (wr_if.DONE) begin
        if (c1 < 0) c1 = k;
        else if (c2 < 0) begin
          c2 = k;
          wr_if.GO = 1'b0;
        end
      end
    end
    wr_if.GO = 1'b0;
    chk("held first done", 8'(c1), 8'd16);
    chk("held period", 8'(c2 - c1), 8'd18);
    chk("held idle busy", {7'd0, wr_if.BUSY}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
